// File: rtl/p4_router_egress_demux.sv
// Egress demux: steers whole packets from the wide VNP4 egress bus to per-port AXIS outputs by tuser.
// Optional macro P4_ROUTER_EGR_DEMUX_BAD_PORT_CNT_EN adds an out-of-range SOP counter and its clear.

module p4_egr_sat_cnt #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)                 cnt <= '0;
    else if (clear)               cnt <= '0;
    else if (inc && (cnt != '1))  cnt <= cnt + W'(1);
  end
endmodule

module p4_router_egress_demux #(
  parameter int NUM_EGR_PHYS_PORTS = 4,
  parameter int DATA_BYTES         = 64,
  parameter int USER_WIDTH         = 8,
  parameter int EGR_COUNTERS_WIDTH = 48
) (
  input  logic                                                   clk,
  input  logic                                                   aresetn,
  input  logic                                                   egr_bus_tvalid,
  output logic                                                   egr_bus_tready,
  input  logic [DATA_BYTES*8-1:0]                                egr_bus_tdata,
  input  logic [DATA_BYTES-1:0]                                  egr_bus_tkeep,
  input  logic                                                   egr_bus_tlast,
  input  logic [USER_WIDTH-1:0]                                  egr_bus_tuser,
  output logic [NUM_EGR_PHYS_PORTS-1:0]                          egr_ports_tvalid,
  input  logic [NUM_EGR_PHYS_PORTS-1:0]                          egr_ports_tready,
  output logic [DATA_BYTES*8-1:0]                                egr_ports_tdata,
  output logic [DATA_BYTES-1:0]                                  egr_ports_tkeep,
  output logic                                                   egr_ports_tlast,
  input  logic [NUM_EGR_PHYS_PORTS-1:0]                          egr_phys_ports_enable,
  input  logic [NUM_EGR_PHYS_PORTS-1:0]                          egr_cnts_clear,
  output logic [NUM_EGR_PHYS_PORTS-1:0][EGR_COUNTERS_WIDTH-1:0]  egr_pkt_cnt,
  output logic [NUM_EGR_PHYS_PORTS-1:0][EGR_COUNTERS_WIDTH-1:0]  egr_drop_cnt
`ifdef P4_ROUTER_EGR_DEMUX_BAD_PORT_CNT_EN
  ,
  input  logic                                                   egr_bad_port_cnt_clear,
  output logic [EGR_COUNTERS_WIDTH-1:0]                          egr_bad_port_cnt
`endif
);
  localparam int N  = NUM_EGR_PHYS_PORTS;
  localparam int DB = DATA_BYTES * 8;
  localparam int DW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FWD  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  if (USER_WIDTH < DW) begin : g_user_width_check
    $error("USER_WIDTH too narrow to address NUM_EGR_PHYS_PORTS");
  end

  logic [1:0]    state;
  logic [DW-1:0] cur_dest;
  logic          ready_q;

  logic [1:0][DB-1:0]         sk_data;
  logic [1:0][DATA_BYTES-1:0] sk_keep;
  logic [1:0]                 sk_last;
  logic [1:0][DW-1:0]         sk_dest;
  logic                       wr_ptr, rd_ptr;
  logic [1:0]                 count, count_nxt;

  logic          bus_hs, sop_hs, sop_in_range, sop_en, push, pop, head_vld;
  logic [DW-1:0] sop_dest, push_dest, head_dest;
  logic [N-1:0]  pkt_inc, drop_inc;

  // DROP swallows beats regardless of FIFO fullness; otherwise ready tracks free space.
  assign egr_bus_tready = (state == S_DROP) ? 1'b1 : ready_q;
  assign bus_hs         = egr_bus_tvalid && egr_bus_tready;
  assign sop_hs         = bus_hs && (state == S_IDLE);
  // One extra bit so N itself is representable even when USER_WIDTH == clog2(N).
  assign sop_in_range   = {1'b0, egr_bus_tuser} < (USER_WIDTH+1)'(N);
  assign sop_dest       = egr_bus_tuser[DW-1:0];
  assign sop_en         = egr_phys_ports_enable[sop_dest];
  assign push           = bus_hs && (((state == S_IDLE) && sop_in_range && sop_en) || (state == S_FWD));
  assign push_dest      = (state == S_IDLE) ? sop_dest : cur_dest;

  assign head_vld        = (count != 2'd0);
  assign head_dest       = sk_dest[rd_ptr];
  assign pop             = head_vld && egr_ports_tready[head_dest];
  assign egr_ports_tdata = sk_data[rd_ptr];
  assign egr_ports_tkeep = sk_keep[rd_ptr];
  assign egr_ports_tlast = sk_last[rd_ptr];
  assign count_nxt       = count + {1'b0, push} - {1'b0, pop};

  always_comb begin
    egr_ports_tvalid = '0;
    pkt_inc          = '0;
    drop_inc         = '0;
    for (int p = 0; p < N; p++) begin
      egr_ports_tvalid[p] = head_vld && (head_dest == DW'(p));
      pkt_inc[p]          = pop && egr_ports_tlast && (head_dest == DW'(p));
      drop_inc[p]         = sop_hs && sop_in_range && !sop_en && (sop_dest == DW'(p));
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= S_IDLE;
      cur_dest <= '0;
    end else begin
      case (state)
        S_IDLE: if (sop_hs && !egr_bus_tlast) begin
          state    <= (sop_in_range && sop_en) ? S_FWD : S_DROP;
          cur_dest <= sop_dest;
        end
        S_FWD, S_DROP: if (bus_hs && egr_bus_tlast) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sk_data <= '0;
      sk_keep <= '0;
      sk_last <= '0;
      sk_dest <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      ready_q <= 1'b0;
    end else begin
      if (push) begin
        sk_data[wr_ptr] <= egr_bus_tdata;
        sk_keep[wr_ptr] <= egr_bus_tkeep;
        sk_last[wr_ptr] <= egr_bus_tlast;
        sk_dest[wr_ptr] <= push_dest;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count   <= count_nxt;
      ready_q <= (count_nxt != 2'd2);
    end
  end

  for (genvar p = 0; p < N; p++) begin : g_port
    p4_egr_sat_cnt #(.W(EGR_COUNTERS_WIDTH)) u_pkt_cnt (
      .clk(clk), .aresetn(aresetn), .clear(egr_cnts_clear[p]), .inc(pkt_inc[p]), .cnt(egr_pkt_cnt[p])
    );
    p4_egr_sat_cnt #(.W(EGR_COUNTERS_WIDTH)) u_drop_cnt (
      .clk(clk), .aresetn(aresetn), .clear(egr_cnts_clear[p]), .inc(drop_inc[p]), .cnt(egr_drop_cnt[p])
    );
  end

`ifdef P4_ROUTER_EGR_DEMUX_BAD_PORT_CNT_EN
  p4_egr_sat_cnt #(.W(EGR_COUNTERS_WIDTH)) u_bad_cnt (
    .clk(clk), .aresetn(aresetn), .clear(egr_bad_port_cnt_clear),
    .inc(sop_hs && !sop_in_range), .cnt(egr_bad_port_cnt)
  );
`else
  // Out-of-range SOPs are discarded with no bookkeeping.
`endif

endmodule

// File: tb/tb_p4_router_egress_demux.sv
// Directed bench for p4_router_egress_demux: N=4, 8-byte bus, 2-bit counters so saturation is reachable.
module tb_p4_router_egress_demux;
  localparam int N  = 4;
  localparam int DB = 8;
  localparam int UW = 8;
  localparam int CW = 2;

  logic                 clk = 1'b0;
  logic                 aresetn = 1'b0;
  logic                 egr_bus_tvalid, egr_bus_tready, egr_bus_tlast;
  logic [DB*8-1:0]      egr_bus_tdata;
  logic [DB-1:0]        egr_bus_tkeep;
  logic [UW-1:0]        egr_bus_tuser;
  logic [N-1:0]         egr_ports_tvalid, egr_ports_tready;
  logic [DB*8-1:0]      egr_ports_tdata;
  logic [DB-1:0]        egr_ports_tkeep;
  logic                 egr_ports_tlast;
  logic [N-1:0]         egr_phys_ports_enable, egr_cnts_clear;
  logic [N-1:0][CW-1:0] egr_pkt_cnt, egr_drop_cnt;
`ifdef P4_ROUTER_EGR_DEMUX_BAD_PORT_CNT_EN
  logic                 egr_bad_port_cnt_clear;
  logic [CW-1:0]        egr_bad_port_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  p4_router_egress_demux #(
    .NUM_EGR_PHYS_PORTS(N), .DATA_BYTES(DB), .USER_WIDTH(UW), .EGR_COUNTERS_WIDTH(CW)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .egr_bus_tvalid(egr_bus_tvalid), .egr_bus_tready(egr_bus_tready),
    .egr_bus_tdata(egr_bus_tdata), .egr_bus_tkeep(egr_bus_tkeep),
    .egr_bus_tlast(egr_bus_tlast), .egr_bus_tuser(egr_bus_tuser),
    .egr_ports_tvalid(egr_ports_tvalid), .egr_ports_tready(egr_ports_tready),
    .egr_ports_tdata(egr_ports_tdata), .egr_ports_tkeep(egr_ports_tkeep),
    .egr_ports_tlast(egr_ports_tlast),
    .egr_phys_ports_enable(egr_phys_ports_enable), .egr_cnts_clear(egr_cnts_clear),
    .egr_pkt_cnt(egr_pkt_cnt), .egr_drop_cnt(egr_drop_cnt)
`ifdef P4_ROUTER_EGR_DEMUX_BAD_PORT_CNT_EN
    , .egr_bad_port_cnt_clear(egr_bad_port_cnt_clear), .egr_bad_port_cnt(egr_bad_port_cnt)
`endif
  );

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [UW-1:0] u, input logic [DB*8-1:0] d,
                       input logic l, input logic [DB-1:0] k = '1);
    egr_bus_tvalid = v; egr_bus_tuser = u; egr_bus_tdata = d; egr_bus_tlast = l; egr_bus_tkeep = k;
  endtask

  task automatic test_reset;
    #1;
    vectors++; if (egr_ports_tvalid !== 4'b0000) begin miscompares++; $display("FAIL reset_tvalid: got %b exp 0000", egr_ports_tvalid); end
    vectors++; if (egr_bus_tready !== 1'b0) begin miscompares++; $display("FAIL reset_tready: got %b exp 0", egr_bus_tready); end
    vectors++; if (egr_pkt_cnt !== '0 || egr_drop_cnt !== '0) begin miscompares++; $display("FAIL reset_cnts: pkt %h drop %h exp 0", egr_pkt_cnt, egr_drop_cnt); end
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
    tick;
    vectors++; if (egr_bus_tready !== 1'b1) begin miscompares++; $display("FAIL post_reset_tready: got %b exp 1", egr_bus_tready); end
  endtask

  task automatic test_fwd;
    drive(1'b1, 8'd2, 64'hA0, 1'b0, 8'h0F);
    for (int i = 0; i < 3; i++) begin
      vectors++; if (egr_bus_tready !== 1'b1) begin miscompares++; $display("FAIL fwd_bus_tready beat%0d: got %b exp 1", i, egr_bus_tready); end
      tick;
      vectors++; if (egr_ports_tvalid !== 4'b0100) begin miscompares++; $display("FAIL fwd_tvalid beat%0d: got %b exp 0100", i, egr_ports_tvalid); end
      vectors++; if (egr_ports_tdata !== 64'hA0 + 64'(i)) begin miscompares++; $display("FAIL fwd_tdata beat%0d: got %h exp %h", i, egr_ports_tdata, 64'hA0 + 64'(i)); end
      vectors++; if (egr_ports_tlast !== (i == 2)) begin miscompares++; $display("FAIL fwd_tlast beat%0d: got %b exp %b", i, egr_ports_tlast, (i == 2)); end
      if (i == 0) begin
        vectors++; if (egr_ports_tkeep !== 8'h0F) begin miscompares++; $display("FAIL fwd_tkeep: got %h exp 0f", egr_ports_tkeep); end
      end
      // Non-first beats carry a different tuser to show it is ignored mid-packet.
      if (i < 2) drive(1'b1, 8'd0, 64'hA0 + 64'(i + 1), i == 1);
      else       drive(1'b0, 8'd0, 64'h0, 1'b0);
    end
    tick;
    vectors++; if (egr_ports_tvalid !== 4'b0000) begin miscompares++; $display("FAIL fwd_idle_tvalid: got %b exp 0000", egr_ports_tvalid); end
    vectors++; if (egr_pkt_cnt[2] !== 2'd1) begin miscompares++; $display("FAIL fwd_pkt_cnt2: got %0d exp 1", egr_pkt_cnt[2]); end
  endtask

  task automatic test_drop;
    egr_phys_ports_enable = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, (i == 0) ? 8'd1 : 8'd0, 64'hD0 + 64'(i), i == 4);
      vectors++; if (egr_bus_tready !== 1'b1) begin miscompares++; $display("FAIL drop_tready beat%0d: got %b exp 1", i, egr_bus_tready); end
      vectors++; if (egr_ports_tvalid !== 4'b0000) begin miscompares++; $display("FAIL drop_tvalid beat%0d: got %b exp 0000", i, egr_ports_tvalid); end
      tick;
    end
    drive(1'b0, 8'd0, 64'h0, 1'b0);
    egr_phys_ports_enable = 4'b1111;
    vectors++; if (egr_ports_tvalid !== 4'b0000) begin miscompares++; $display("FAIL drop_tail_tvalid: got %b exp 0000", egr_ports_tvalid); end
    vectors++; if (egr_drop_cnt[1] !== 2'd1) begin miscompares++; $display("FAIL drop_cnt1: got %0d exp 1", egr_drop_cnt[1]); end
    vectors++; if (egr_pkt_cnt[1] !== 2'd0) begin miscompares++; $display("FAIL drop_pkt_cnt1: got %0d exp 0", egr_pkt_cnt[1]); end
  endtask

  task automatic test_bad_port;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, (i == 0) ? 8'd7 : 8'd3, 64'hB0 + 64'(i), i == 2);
      vectors++; if (egr_bus_tready !== 1'b1) begin miscompares++; $display("FAIL bad_tready beat%0d: got %b exp 1", i, egr_bus_tready); end
      vectors++; if (egr_ports_tvalid !== 4'b0000) begin miscompares++; $display("FAIL bad_tvalid beat%0d: got %b exp 0000", i, egr_ports_tvalid); end
      tick;
    end
    drive(1'b0, 8'd0, 64'h0, 1'b0);
    vectors++; if (egr_ports_tvalid !== 4'b0000) begin miscompares++; $display("FAIL bad_tail_tvalid: got %b exp 0000", egr_ports_tvalid); end
    vectors++; if (egr_drop_cnt[3] !== 2'd0 || egr_pkt_cnt[3] !== 2'd0) begin miscompares++; $display("FAIL bad_port3_cnts: drop %0d pkt %0d exp 0 0", egr_drop_cnt[3], egr_pkt_cnt[3]); end
`ifdef P4_ROUTER_EGR_DEMUX_BAD_PORT_CNT_EN
    vectors++; if (egr_bad_port_cnt !== 2'd1) begin miscompares++; $display("FAIL bad_port_cnt: got %0d exp 1", egr_bad_port_cnt); end
`endif
  endtask

  task automatic test_back_to_back;
    egr_cnts_clear = 4'hF;
    tick;
    egr_cnts_clear = 4'h0;
    vectors++; if (egr_pkt_cnt !== '0 || egr_drop_cnt !== '0) begin miscompares++; $display("FAIL b2b_clear: pkt %h drop %h exp 0", egr_pkt_cnt, egr_drop_cnt); end
    egr_ports_tready = 4'b0111;
    drive(1'b1, 8'd0, 64'hC0, 1'b1);
    vectors++; if (egr_bus_tready !== 1'b1) begin miscompares++; $display("FAIL b2b_c0_tready: got %b exp 1", egr_bus_tready); end
    tick;
    vectors++; if (egr_ports_tvalid !== 4'b0001 || egr_ports_tdata !== 64'hC0) begin miscompares++; $display("FAIL b2b_c1_out: tvalid %b data %h exp 0001 c0", egr_ports_tvalid, egr_ports_tdata); end
    drive(1'b1, 8'd3, 64'hC1, 1'b1);
    vectors++; if (egr_bus_tready !== 1'b1) begin miscompares++; $display("FAIL b2b_c1_tready: got %b exp 1", egr_bus_tready); end
    tick;
    drive(1'b1, 8'd0, 64'hC2, 1'b1);
    vectors++; if (egr_bus_tready !== 1'b1) begin miscompares++; $display("FAIL b2b_c2_tready: got %b exp 1", egr_bus_tready); end
    for (int c = 2; c < 7; c++) begin
      if (c == 6) egr_ports_tready = 4'b1111;
      vectors++; if (egr_ports_tvalid !== 4'b1000 || egr_ports_tdata !== 64'hC1) begin miscompares++; $display("FAIL b2b_c%0d_out: tvalid %b data %h exp 1000 c1", c, egr_ports_tvalid, egr_ports_tdata); end
      if (c >= 3 && c <= 5) begin
        vectors++; if (egr_bus_tready !== 1'b0) begin miscompares++; $display("FAIL b2b_c%0d_full_tready: got %b exp 0", c, egr_bus_tready); end
      end
      tick;
      if (c == 2) drive(1'b0, 8'd0, 64'h0, 1'b0);
    end
    vectors++; if (egr_ports_tvalid !== 4'b0001 || egr_ports_tdata !== 64'hC2) begin miscompares++; $display("FAIL b2b_c7_out: tvalid %b data %h exp 0001 c2", egr_ports_tvalid, egr_ports_tdata); end
    vectors++; if (egr_bus_tready !== 1'b1) begin miscompares++; $display("FAIL b2b_c7_tready: got %b exp 1", egr_bus_tready); end
    tick;
    vectors++; if (egr_ports_tvalid !== 4'b0000) begin miscompares++; $display("FAIL b2b_drain_tvalid: got %b exp 0000", egr_ports_tvalid); end
    vectors++; if (egr_pkt_cnt[0] !== 2'd2 || egr_pkt_cnt[3] !== 2'd1) begin miscompares++; $display("FAIL b2b_cnts: p0 %0d p3 %0d exp 2 1", egr_pkt_cnt[0], egr_pkt_cnt[3]); end
  endtask

  task automatic test_saturation;
    egr_cnts_clear = 4'hF;
    tick;
    egr_cnts_clear = 4'h0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 8'd0, 64'(k), 1'b1);
      tick;
    end
    drive(1'b0, 8'd0, 64'h0, 1'b0);
    tick; tick;
    vectors++; if (egr_pkt_cnt[0] !== 2'd3) begin miscompares++; $display("FAIL sat_hold: got %0d exp 3", egr_pkt_cnt[0]); end
    drive(1'b1, 8'd0, 64'h55, 1'b1);
    tick;
    drive(1'b0, 8'd0, 64'h0, 1'b0);
    vectors++; if (egr_ports_tvalid !== 4'b0001 || egr_ports_tlast !== 1'b1) begin miscompares++; $display("FAIL sat_last_beat: tvalid %b tlast %b exp 0001 1", egr_ports_tvalid, egr_ports_tlast); end
    egr_cnts_clear = 4'b0001;
    tick;
    egr_cnts_clear = 4'b0000;
    vectors++; if (egr_pkt_cnt[0] !== 2'd0) begin miscompares++; $display("FAIL sat_clear_prio: got %0d exp 0", egr_pkt_cnt[0]); end
    tick;
    vectors++; if (egr_pkt_cnt[0] !== 2'd0) begin miscompares++; $display("FAIL sat_clear_hold: got %0d exp 0", egr_pkt_cnt[0]); end
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 8'd2, 64'hE9, 1'b1);
    tick;
    drive(1'b1, 8'd1, 64'hE1, 1'b0);
    tick;
    drive(1'b1, 8'd0, 64'hE2, 1'b0);
    tick;
    drive(1'b0, 8'd0, 64'h0, 1'b0);
    vectors++; if (egr_ports_tvalid !== 4'b0010 || egr_pkt_cnt[2] !== 2'd1) begin miscompares++; $display("FAIL rstmid_pre: tvalid %b p2 %0d exp 0010 1", egr_ports_tvalid, egr_pkt_cnt[2]); end
    aresetn = 1'b0;
    #1;
    vectors++; if (egr_ports_tvalid !== 4'b0000 || egr_bus_tready !== 1'b0) begin miscompares++; $display("FAIL rstmid_outs: tvalid %b tready %b exp 0000 0", egr_ports_tvalid, egr_bus_tready); end
    vectors++; if (egr_pkt_cnt !== '0 || egr_ports_tdata !== 64'h0) begin miscompares++; $display("FAIL rstmid_state: pkt %h data %h exp 0 0", egr_pkt_cnt, egr_ports_tdata); end
    tick;
    aresetn = 1'b1;
    tick;
    drive(1'b1, 8'd3, 64'hF0, 1'b0);
    vectors++; if (egr_bus_tready !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready: got %b exp 1", egr_bus_tready); end
    tick;
    vectors++; if (egr_ports_tvalid !== 4'b1000 || egr_ports_tdata !== 64'hF0) begin miscompares++; $display("FAIL rstmid_sop: tvalid %b data %h exp 1000 f0", egr_ports_tvalid, egr_ports_tdata); end
    drive(1'b1, 8'd1, 64'hF1, 1'b1);
    tick;
    drive(1'b0, 8'd0, 64'h0, 1'b0);
    vectors++; if (egr_ports_tvalid !== 4'b1000 || egr_ports_tlast !== 1'b1) begin miscompares++; $display("FAIL rstmid_eop: tvalid %b tlast %b exp 1000 1", egr_ports_tvalid, egr_ports_tlast); end
    tick;
    vectors++; if (egr_pkt_cnt[3] !== 2'd1 || egr_ports_tvalid !== 4'b0000) begin miscompares++; $display("FAIL rstmid_cnt: p3 %0d tvalid %b exp 1 0000", egr_pkt_cnt[3], egr_ports_tvalid); end
  endtask

  initial begin
    drive(1'b0, 8'd0, 64'h0, 1'b0);
    egr_ports_tready      = 4'hF;
    egr_phys_ports_enable = 4'hF;
    egr_cnts_clear        = 4'h0;
`ifdef P4_ROUTER_EGR_DEMUX_BAD_PORT_CNT_EN
    egr_bad_port_cnt_clear = 1'b0;
`endif
    test_reset;
    test_fwd;
    test_drop;
    test_bad_port;
    test_back_to_back;
    test_saturation;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
